// File: rtl/add_sub_seq16.sv
// Nibble-serial adder/subtractor. One 4-bit add/sub slice is reused over N_NIBBLES
// cycles, LSB nibble first, and the result is published only when the operation completes.
module add_sub_seq16 #(
    parameter int N_NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [4*N_NIBBLES-1:0] i_A,
    input  logic [4*N_NIBBLES-1:0] i_B,
    input  logic                   i_Mode,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*N_NIBBLES-1:0] o_Sum,
    output logic                   o_Cout,
    output logic                   o_Zero,
    output logic                   o_Ovf
);
    localparam int W  = 4 * N_NIBBLES;
    localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(N_NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic          r_mode;
    logic          r_carry;
    logic          r_a_msb;
    logic          r_beff_msb;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_b_eff;
    logic [4:0]    w_slice;
    logic [W-1:0]  w_acc_next;

    // Operands shift right each slice, so the active nibble is always bits [3:0].
    assign w_b_eff    = r_b[3:0] ^ {4{r_mode}};
    assign w_slice    = {1'b0, r_a[3:0]} + {1'b0, w_b_eff} + {4'b0000, r_carry};
    assign w_acc_next = (r_acc >> 4) | (W'(w_slice[3:0]) << (W - 4));

    // NOTE: every register here uses non-blocking assignment so all state updates
    // take effect together at the clock edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_mode     <= 1'b0;
            r_carry    <= 1'b0;
            r_a_msb    <= 1'b0;
            r_beff_msb <= 1'b0;
            r_cnt      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_Sum      <= '0;
            o_Cout     <= 1'b0;
            o_Zero     <= 1'b1;
            o_Ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= S_RUN;
                        r_a        <= i_A;
                        r_b        <= i_B;
                        r_acc      <= '0;
                        r_mode     <= i_Mode;
                        r_carry    <= i_Mode;
                        r_a_msb    <= i_A[W-1];
                        r_beff_msb <= i_B[W-1] ^ i_Mode;
                        r_cnt      <= '0;
                        o_busy     <= 1'b1;
                    end
                end

                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice[4];
                    if (r_cnt == LAST_SLICE) begin
                        // Final slice: its top bit is the sign bit of the full result.
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_Sum   <= w_acc_next;
                        o_Cout  <= w_slice[4];
                        o_Zero  <= (w_acc_next == '0);
                        o_Ovf   <= (r_a_msb == r_beff_msb) && (w_slice[3] != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/add_sub_seq16.md
ADD_SUB_SEQ16 -- requirements
Module: add_sub_seq16

Interface
REQ-001 SHALL have parameter N_NIBBLES, default 4, meaning number of 4-bit slices per operand; operand width W = 4*N_NIBBLES.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 i_clk  input  1  rising-edge clock for all state.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 i_A  input  W  operand A, captured when i_start is accepted.
REQ-007 i_B  input  W  operand B, captured when i_start is accepted.
REQ-008 i_Mode  input  1  0 = A+B, 1 = A-B; captured when i_start is accepted.
REQ-009 o_busy  output  1  high in RUN and DONE states.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_Sum  output  W  result of the last completed operation.
REQ-012 o_Cout  output  1  final carry; in subtract mode 1 = no borrow.
REQ-013 o_Zero  output  1  high when o_Sum is all zeros.
REQ-014 o_Ovf  output  1  two's-complement signed overflow of the last completed operation.

Function
REQ-015 SHALL compute the W-bit result serially, one 4-bit slice per clock, LSB nibble first, using one internal 4-bit add/sub slice with carry-in.
REQ-016 Per slice: {c_out, s} = A_n + (B_n XOR {4{mode}}) + c_in; carry register initialised to captured mode on accept (subtract = A + ~B + 1).
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on i_start; RUN->DONE after N_NIBBLES slice cycles; DONE->IDLE unconditionally after one cycle.
REQ-018 Accept edge: i_start high in IDLE; operands, mode captured into internal registers, slice counter cleared, carry set to mode.
REQ-019 Each RUN edge: slice n result written into result shift/accumulator register, carry register updated, counter incremented; counter wraps to 0 on entering DONE.
REQ-020 Latency: o_done high in the cycle following the N_NIBBLES-th RUN edge, i.e. N_NIBBLES+1 edges after the accept edge (5 for default).
REQ-021 o_Sum, o_Cout, o_Zero, o_Ovf SHALL update only on the edge entering DONE and hold until the next completion; no intermediate slice values visible.
REQ-022 o_Ovf = (A[W-1] == Beff[W-1]) AND (Sum[W-1] != A[W-1]), Beff = B XOR {W{mode}}.
REQ-023 i_start in RUN or DONE SHALL be ignored (no queueing); input changes after accept SHALL not affect the operation.
REQ-024 Back-to-back: i_start held high continuously yields one accept per N_NIBBLES+2 cycles.
REQ-025 o_done SHALL be exactly one cycle wide; o_busy low only in IDLE.

Reset
REQ-026 i_reset high at a rising edge SHALL force IDLE, counter 0, carry 0, o_busy 0, o_done 0, o_Sum 0, o_Cout 0, o_Ovf 0; o_Zero 1.
REQ-027 Reset SHALL take priority over i_start and over any RUN/DONE activity; an operation interrupted by reset SHALL produce no o_done and no output update.

Verification
REQ-028 Reset: assert i_reset 2 cycles -> o_busy 0, o_done 0, o_Sum 0x0000, o_Cout 0, o_Zero 1, o_Ovf 0.
REQ-029 Add: A=0x1234, B=0x0FCD, Mode=0 -> o_done exactly 5 edges after accept, o_Sum 0x2201, o_Cout 0, o_Ovf 0.
REQ-030 Subtract: A=0x000A, B=0x0009, Mode=1 -> o_Sum 0x0001, o_Cout 1; then A=0x0008, B=0x000A, Mode=1 -> o_Sum 0xFFFE, o_Cout 0.
REQ-031 Wrap/flags: A=0xFFFF, B=0x0001, Mode=0 -> o_Sum 0x0000, o_Cout 1, o_Zero 1, o_Ovf 0; A=0x7FFF, B=0x0001, Mode=0 -> o_Sum 0x8000, o_Ovf 1.
REQ-032 Busy/ignore: pulse i_start with new operands during RUN and DONE -> ignored, single o_done, result of the first operation only; held i_start -> accepts spaced 6 cycles.
REQ-033 Reset mid-RUN: assert i_reset on 2nd RUN edge -> IDLE next cycle, no o_done, outputs at reset values; subsequent start completes correctly.
